decode_stage_pipe: RTL and testbench

Parametrised instruction-decode stage for the MIPS-subset core, sitting between fetch and execute. Contains the register file, main decode and immediate/jump-target generation. Drives a registered ID/EX pipeline register with a valid/ready handshake. Adds load-use hazard stalling, flush and bubble insertion, and optional write-back bypass.

---
 rtl/decode_pkg.sv | 69 ++++++
 rtl/decode_stage_pipe_reg_file.sv | 45 ++++
 rtl/decode_stage_pipe.sv | 181 ++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, ALU classes, stall FSM states and control bundle for the decode stage
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
    } ctrl_t;

    // Unknown opcodes fall through as a live NOP with every control low.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.alu_op    = ALU_RTYPE;
                c.reg_write = 1'b1;
            end
            OP_ADDI: begin
                c.alu_op    = ALU_ADD;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.alu_op     = ALU_ADD;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OP_SW: begin
                c.alu_op    = ALU_ADD;
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                c.alu_op = ALU_SUB;
                c.branch = 1'b1;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_reg_file.sv
// rtl/decode_stage_pipe_reg_file.sv - register file, two async read ports and one clocked write port
module reg_file_p
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we && !(ZERO_REG && (waddr == '0))) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // A same-cycle write is not visible here; the array only changes on the edge.
    assign rdata_a = (ZERO_REG && (raddr_a == '0)) ? '0 : mem_q[raddr_a];
    assign rdata_b = (ZERO_REG && (raddr_b == '0)) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - MIPS-subset decode stage with ID/EX register; DECODE_WB_BYPASS_EN adds write-back bypass
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_jtarget,
    output logic [AW-1:0]   ex_dst,
    output logic [AW-1:0]   ex_rs,
    output logic [AW-1:0]   ex_rt,
    output logic [2:0]      ex_alu_op,
    output logic [5:0]      ex_func,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_alu_src,
    output logic            ex_branch,
    output logic            ex_jump
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs_data;
        logic [XLEN-1:0] rt_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] jtarget;
        logic [AW-1:0]   dst;
        logic [AW-1:0]   rs;
        logic [AW-1:0]   rt;
        logic [5:0]      func;
        ctrl_t           ctrl;
    } idex_t;

    idex_t  idex_q, idex_d, fetched;
    state_e state_q, state_d;

    logic [5:0]      opcode;
    logic [AW-1:0]   rs_idx, rt_idx, rd_idx;
    logic [XLEN-1:0] rf_rs, rf_rt, rs_val, rt_val, pc4;
    logic            adv, hz, accept;

    assign opcode = if_instr[31:26];
    assign rs_idx = if_instr[21 +: AW];
    assign rt_idx = if_instr[16 +: AW];
    assign rd_idx = if_instr[11 +: AW];

    reg_file_p #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .ZERO_REG(ZERO_REG)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr_a(rs_idx),
        .rdata_a(rf_rs),
        .raddr_b(rt_idx),
        .rdata_b(rf_rt)
    );

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        rs_val = rf_rs;
        rt_val = rf_rt;
        if (wb_we && (wb_addr == rs_idx) && !(ZERO_REG && (rs_idx == '0))) rs_val = wb_data;
        if (wb_we && (wb_addr == rt_idx) && !(ZERO_REG && (rt_idx == '0))) rt_val = wb_data;
    end
`else
    assign rs_val = rf_rs;
    assign rt_val = rf_rt;
`endif

    assign adv = ex_ready | ~idex_q.valid;
    assign hz  = if_valid & idex_q.valid & idex_q.ctrl.mem_read & idex_q.ctrl.reg_write
               & ((idex_q.dst == rs_idx) | (idex_q.dst == rt_idx))
               & ~(ZERO_REG & (idex_q.dst == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (hz && adv) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;
    end

    // The bubble loaded on entry to STALL empties ID/EX, so the retry is always taken.
    always_comb begin
        id_ready = 1'b0;
        if (!flush) begin
            id_ready = (state_q == ST_STALL) ? 1'b1 : (adv & ~hz);
        end
    end

    assign accept = if_valid & id_ready;
    assign pc4    = if_pc + XLEN'(4);

    always_comb begin
        fetched         = '0;
        fetched.valid   = 1'b1;
        fetched.pc      = if_pc;
        fetched.rs_data = rs_val;
        fetched.rt_data = rt_val;
        fetched.imm     = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
        fetched.jtarget = (pc4 & ~XLEN'(32'h0FFF_FFFF)) | XLEN'({if_instr[25:0], 2'b00});
        fetched.dst     = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
        fetched.rs      = rs_idx;
        fetched.rt      = rt_idx;
        fetched.func    = if_instr[5:0];
        fetched.ctrl    = decode_ctrl(opcode);
    end

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (adv) begin
            idex_d = accept ? fetched : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ex_valid      = idex_q.valid;
    assign ex_pc         = idex_q.pc;
    assign ex_rs_data    = idex_q.rs_data;
    assign ex_rt_data    = idex_q.rt_data;
    assign ex_imm        = idex_q.imm;
    assign ex_jtarget    = idex_q.jtarget;
    assign ex_dst        = idex_q.dst;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign ex_func       = idex_q.func;
    assign ex_alu_op     = idex_q.ctrl.alu_op;
    assign ex_mem_read   = idex_q.ctrl.mem_read;
    assign ex_mem_write  = idex_q.ctrl.mem_write;
    assign ex_reg_write  = idex_q.ctrl.reg_write;
    assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign ex_alu_src    = idex_q.ctrl.alu_src;
    assign ex_branch     = idex_q.ctrl.branch;
    assign ex_jump       = idex_q.ctrl.jump;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - directed and randomized bench for decode_stage_pipe against a slot-level model
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid, flush, ex_ready, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_addr;
    logic        id_ready, ex_valid;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget;
    logic [4:0]  ex_dst, ex_rs, ex_rt;
    logic [2:0]  ex_alu_op;
    logic [5:0]  ex_func;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_jump;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_jtarget(ex_jtarget), .ex_dst(ex_dst), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_alu_op(ex_alu_op), .ex_func(ex_func), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc, rsd, rtd, imm, jt;
        logic [4:0]  dst, rs, rt;
        logic [2:0]  aluop;
        logic [5:0]  func;
        logic        mr, mw, rw, m2r, as, br, jp;
    } slot_t;

    slot_t       m;
    logic [31:0] regs [32];
    int          checks = 0;
    int          errors = 0;
    logic        last_rdy;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic slot_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
        slot_t s;
        s       = empty_slot();
        s.valid = 1'b1;
        s.pc    = pc;
        s.rsd   = a;
        s.rtd   = b;
        s.imm   = {{16{ins[15]}}, ins[15:0]};
        s.jt    = ((pc + 32'd4) & 32'hF000_0000) | {4'h0, ins[25:0], 2'b00};
        s.rs    = ins[25:21];
        s.rt    = ins[20:16];
        s.dst   = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
        s.func  = ins[5:0];
        case (ins[31:26])
            6'h00: begin s.aluop = 3'b010; s.rw = 1'b1; end
            6'h08: begin s.as = 1'b1; s.rw = 1'b1; end
            6'h23: begin s.as = 1'b1; s.mr = 1'b1; s.m2r = 1'b1; s.rw = 1'b1; end
            6'h2B: begin s.as = 1'b1; s.mw = 1'b1; end
            6'h04: begin s.aluop = 3'b001; s.br = 1'b1; end
            6'h02: s.jp = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic [191:0] pack(input slot_t s, input logic full);
        if (full)
            return {s.valid, s.pc, s.rsd, s.rtd, s.imm, s.jt, s.dst, s.rs, s.rt, s.aluop, s.func,
                    s.mr, s.mw, s.rw, s.m2r, s.as, s.br, s.jp};
        return {s.valid, 175'h0, s.aluop, 6'h0, s.mr, s.mw, s.rw, s.m2r, s.as, s.br, s.jp};
    endfunction

    function automatic slot_t dut_slot();
        slot_t s;
        s.valid = ex_valid;  s.pc = ex_pc;   s.rsd = ex_rs_data; s.rtd = ex_rt_data;
        s.imm = ex_imm;      s.jt = ex_jtarget; s.dst = ex_dst;  s.rs = ex_rs; s.rt = ex_rt;
        s.aluop = ex_alu_op; s.func = ex_func;
        s.mr = ex_mem_read;  s.mw = ex_mem_write; s.rw = ex_reg_write; s.m2r = ex_mem_to_reg;
        s.as = ex_alu_src;   s.br = ex_branch;    s.jp = ex_jump;
        return s;
    endfunction

    // A live load in EX whose destination the fetched instruction reads (r0 never counts).
    function automatic logic ready_model();
        logic hz;
        hz = if_valid && m.valid && m.mr && m.rw && (m.dst != 5'd0)
             && ((m.dst == if_instr[25:21]) || (m.dst == if_instr[20:16]));
        return !flush && (ex_ready || !m.valid) && !hz;
    endfunction

    task automatic model_step();
        logic        rdy;
        logic [31:0] a, b;
        rdy = ready_model();
        a   = regs[if_instr[25:21]];
        b   = regs[if_instr[20:16]];
        if (BYPASS && wb_we && wb_addr != 5'd0 && wb_addr == if_instr[25:21]) a = wb_data;
        if (BYPASS && wb_we && wb_addr != 5'd0 && wb_addr == if_instr[20:16]) b = wb_data;
        if (flush) m = empty_slot();
        else if (ex_ready || !m.valid) m = (if_valid && rdy) ? decode(if_instr, if_pc, a, b) : empty_slot();
        if (wb_we && wb_addr != 5'd0) regs[wb_addr] = wb_data;
    endtask

    task automatic model_reset();
        m = empty_slot();
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        last_rdy = id_ready;
        check({tag, "_id_ready"}, 192'(id_ready), 192'(ready_model()));
        @(posedge clk);
        model_step();
        #1;
        check({tag, "_idex"}, pack(dut_slot(), m.valid), pack(m, m.valid));
    endtask

    task automatic fetch(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        wb_we   = we;
        wb_addr = addr;
        wb_data = data;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [5:0] ops [7];

    initial begin
        ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        fetch(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        flush    = 1'b0;
        ex_ready = 1'b1;
        model_reset();

        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_id_ready", 192'(id_ready), 192'd1);
        check("reset_outputs", pack(dut_slot(), 1'b1), 192'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        wb(1'b1, 5'd5, 32'h1234);
        cycle("wb_r5");
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b1, rtype(5'd3, 5'd5, 5'd0), 32'h100);
        cycle("add_r3");
        check("add_rs_data", 192'(ex_rs_data), 192'h1234);
        check("add_rt_data", 192'(ex_rt_data), 192'h0);
        check("add_dst", 192'(ex_dst), 192'd3);
        check("add_alu_op", 192'(ex_alu_op), 192'b010);

        fetch(1'b1, itype(6'h23, 5'd2, 5'd1, 16'd4), 32'h104);
        cycle("lw_r2");
        fetch(1'b1, rtype(5'd4, 5'd2, 5'd1), 32'h108);
        cycle("lu_stall");
        check("lu_stall_ready", 192'(last_rdy), 192'd0);
        check("lu_bubble", 192'(ex_valid), 192'd0);
        cycle("lu_issue");
        check("lu_issue_valid", 192'(ex_valid), 192'd1);
        check("lu_issue_pc", 192'(ex_pc), 192'h108);
        fetch(1'b1, rtype(5'd5, 5'd2, 5'd4), 32'h10C);
        cycle("no_second_bubble");
        check("no_second_bubble_pc", 192'(ex_pc), 192'h10C);

        fetch(1'b1, itype(6'h08, 5'd7, 5'd0, 16'hFFFF), 32'h110);
        cycle("addi_m1");
        check("addi_imm", 192'(ex_imm), 192'hFFFF_FFFF);
        check("addi_alu_src", 192'(ex_alu_src), 192'd1);
        fetch(1'b1, {6'h02, 26'h10}, 32'h4000_0000);
        cycle("jump");
        check("j_target", 192'(ex_jtarget), 192'h4000_0040);
        check("j_jump", 192'(ex_jump), 192'd1);

        fetch(1'b1, itype(6'h2B, 5'd3, 5'd1, 16'h8), 32'h200);
        cycle("sw_load");
        ex_ready = 1'b0;
        fetch(1'b1, itype(6'h04, 5'd2, 5'd1, 16'h3), 32'h204);
        for (int i = 0; i < 3; i++) begin
            cycle("backpressure");
            check("bp_hold_pc", 192'(ex_pc), 192'h200);
            check("bp_ready", 192'(last_rdy), 192'd0);
        end
        ex_ready = 1'b1;
        cycle("bp_release");
        check("bp_release_pc", 192'(ex_pc), 192'h204);
        check("bp_release_branch", 192'(ex_branch), 192'd1);

        fetch(1'b1, itype(6'h23, 5'd2, 5'd1, 16'd0), 32'h300);
        cycle("fl_lw");
        fetch(1'b1, rtype(5'd4, 5'd2, 5'd1), 32'h304);
        cycle("fl_stall");
        flush = 1'b1;
        cycle("fl_flush");
        check("fl_flush_ready", 192'(last_rdy), 192'd0);
        check("fl_flush_valid", 192'(ex_valid), 192'd0);
        flush = 1'b0;
        cycle("fl_after");
        check("fl_after_ready", 192'(last_rdy), 192'd1);
        check("fl_after_valid", 192'(ex_valid), 192'd1);

        fetch(1'b0, 32'h0, 32'h0);
        wb(1'b1, 5'd0, 32'hFFFF);
        cycle("wr_r0");
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b1, rtype(5'd1, 5'd0, 5'd0), 32'h400);
        cycle("rd_r0");
        check("r0_rs_data", 192'(ex_rs_data), 192'h0);
        check("r0_rt_data", 192'(ex_rt_data), 192'h0);

        wb(1'b1, 5'd9, 32'hAB);
        fetch(1'b1, rtype(5'd1, 5'd9, 5'd0), 32'h404);
        cycle("wb_same_cycle");
        check("wb_bypass_rs", 192'(ex_rs_data), BYPASS ? 192'hAB : 192'h0);
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b1, rtype(5'd1, 5'd0, 5'd9), 32'h408);
        cycle("wb_later");
        check("wb_later_rt", 192'(ex_rt_data), 192'hAB);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            fetch($urandom_range(0, 3) != 0,
                  {ops[$urandom_range(0, 6)], 2'b00, r[2:0], 2'b00, r[5:3], 2'b00, r[8:6], r[19:9]},
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            ex_ready = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 15) == 0;
            wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            cycle("random");
        end

        flush    = 1'b0;
        ex_ready = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        fetch(1'b1, itype(6'h23, 5'd2, 5'd1, 16'd0), 32'h500);
        cycle("rs_lw");
        fetch(1'b1, rtype(5'd4, 5'd2, 5'd1), 32'h504);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("midstall_reset_valid", 192'(ex_valid), 192'd0);
        check("midstall_reset_ready", 192'(id_ready), 192'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        cycle("post_reset");
        check("post_reset_valid", 192'(ex_valid), 192'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
